// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick serial link (button map, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package joy_db15_pkg;

    localparam int BTN_BITS_DEF = 12;
    localparam int PLAYERS_DEF  = 2;

    // Button bit positions inside one player word
    localparam int BTN_R      = 0;
    localparam int BTN_L      = 1;
    localparam int BTN_D      = 2;
    localparam int BTN_U      = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_C      = 6;
    localparam int BTN_D2     = 7;
    localparam int BTN_E      = 8;
    localparam int BTN_F      = 9;
    localparam int BTN_SELECT = 10;
    localparam int BTN_START  = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Number of serial bits in one frame
    function automatic int frame_bits(input int players, input int btn_bits);
        return players * btn_bits;
    endfunction

endpackage

// File: rtl/joy_db15_sync_edge.sv
// Synchronizes one asynchronous pin and reports its level plus rising/falling edges.
// Latency: SYNC_STAGES clk cycles to level; edges valid in the same cycle as the new level.
// Backpressure: none; free-running, flops reset high so releasing reset shows no edge.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Metastability chain followed by the edge-detect history flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick transmitter: latches two player words on joy_load, shifts them out on joy_clk.
// Latency: pin edge to joy_data change is SYNC_STAGES+1 clk cycles.
// Backpressure: none; the receiver paces the link, joy_load low always restarts a frame.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int BTN_BITS    = BTN_BITS_DEF,
    parameter int PLAYERS     = PLAYERS_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [BTN_BITS-1:0] joy1,
    input  logic [BTN_BITS-1:0] joy2,
    input  logic                joy_clk,
    input  logic                joy_load,
    output logic                joy_data,
    output logic                frame_done,
    output logic [7:0]          frame_cnt,
    output logic                busy
);

    localparam int FRAME = frame_bits(PLAYERS, BTN_BITS);
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME - 1);

    logic clk_lvl, clk_rise, clk_fall;
    logic load_lvl, load_rise, load_fall;

    state_t             state;
    logic [FRAME-1:0]   sreg;
    logic [FRAME-1:0]   load_word;
    logic [CNT_W-1:0]   bit_cnt;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_clk),
        .level   (clk_lvl),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_load),
        .level   (load_lvl),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    // A low load level already covers the falling edge, and clock level/fall carry no meaning here
    logic unused_sync;
    assign unused_sync = &{1'b0, clk_lvl, clk_fall, load_fall};

    // Active-low frame image: player 1 in the low bits so joy1[0] leaves first; unused slots read as pull-ups
    always_comb begin
        load_word = '1;
        for (int i = 0; i < BTN_BITS; i++) begin
            load_word[i] = ~joy1[i];
            if (PLAYERS > 1) begin
                load_word[BTN_BITS + i] = ~joy2[i];
            end
        end
    end

    // Frame FSM; load has priority over everything, so a clock edge coinciding with load never shifts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sreg       <= '1;
            bit_cnt    <= '0;
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!load_lvl) begin
                // Transparent latch phase: track the live button words until load rises
                state    <= ST_LOAD;
                sreg     <= load_word;
                bit_cnt  <= '0;
                joy_data <= ~joy1[BTN_R];
                busy     <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        joy_data <= 1'b1;
                        busy     <= 1'b0;
                    end
                    ST_LOAD: begin
                        // Level is high here only after a rise; the snapshot stays as last loaded
                        if (load_rise) begin
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        if (clk_rise) begin
                            if (bit_cnt == LAST_BIT) begin
                                state      <= ST_DONE;
                                sreg       <= '1;
                                joy_data   <= 1'b1;
                                frame_done <= 1'b1;
                                frame_cnt  <= frame_cnt + 8'd1;
                                busy       <= 1'b0;
                            end else begin
                                sreg     <= {1'b1, sreg[FRAME-1:1]};
                                bit_cnt  <= bit_cnt + CNT_W'(1);
                                joy_data <= sreg[1];
                            end
                        end
                    end
                    ST_DONE: begin
                        // Serial-in is tied high once the chain is empty
                        joy_data <= 1'b1;
                        busy     <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [11:0] joy1     = 12'h000;
    logic [11:0] joy2     = 12'h000;
    logic        joy_clk  = 1'b1;
    logic        joy_load = 1'b1;
    logic        joy_data;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        busy;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    logic sb[$];

    typedef struct {
        logic [11:0] j1;
        logic [11:0] j2;
        logic [23:0] exp;
    } vec_t;

    vec_t vt[5];

    always #5 clk = ~clk;

    joy_db15_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy_clk    (joy_clk),
        .joy_load   (joy_load),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .busy       (busy)
    );

    always @(negedge clk) begin
        if (reset_n && frame_done) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [11:0] j1, input logic [11:0] j2, input int hp);
        joy1     = j1;
        joy2     = j2;
        joy_load = 1'b0;
        tick(hp);
        joy_load = 1'b1;
        tick(hp);
    endtask

    task automatic push_bits(input logic [23:0] e, input int n);
        for (int k = 0; k < n; k++) sb.push_back(e[k]);
    endtask

    // Receiver model: sample joy_data at the end of each low phase, just before the rising edge
    task automatic shift_bits(input int n, input int hp);
        logic exp_b;
        for (int k = 0; k < n; k++) begin
            joy_clk = 1'b0;
            tick(hp - 1);
            @(negedge clk);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got no expected bit want one");
            end else begin
                exp_b = sb.pop_front();
                check("serial_bit", {31'b0, joy_data}, {31'b0, exp_b});
            end
            @(posedge clk);
            #1;
            joy_clk = 1'b1;
            tick(hp);
        end
    endtask

    initial begin
        int d0;
        logic [11:0] rj1, rj2;

        vt[0] = '{12'h001, 12'h800, 24'h7FFFFE};
        vt[1] = '{12'h000, 12'h000, 24'hFFFFFF};
        vt[2] = '{12'hFFF, 12'hFFF, 24'h000000};
        vt[3] = '{12'hA5A, 12'h3C3, 24'hC3C5A5};
        vt[4] = '{12'h123, 12'hF0F, 24'h0F0EDC};

        // Reset state
        tick(3);
        check("rst_joy_data",   {31'b0, joy_data},   32'd1);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_frame_cnt",  {24'b0, frame_cnt},  32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        reset_n = 1'b1;
        tick(100);
        check("idle_joy_data",  {31'b0, joy_data},  32'd1);
        check("idle_busy",      {31'b0, busy},      32'd0);
        check("idle_frame_cnt", {24'b0, frame_cnt}, 32'd0);
        check("idle_done_cnt",  done_cnt,           32'd0);

        // Table-driven full frames
        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            do_load(vt[i].j1, vt[i].j2, 8);
            check("load_busy", {31'b0, busy}, 32'd1);
            push_bits(vt[i].exp, 24);
            shift_bits(24, 8);
            check("vec_done_once", done_cnt, d0 + 1);
            check("vec_frame_cnt", {24'b0, frame_cnt}, i + 1);
            check("vec_after_data", {31'b0, joy_data}, 32'd1);
            check("vec_after_busy", {31'b0, busy}, 32'd0);
        end

        // Snapshot is the last LOAD-cycle value of joy1
        joy1 = 12'h000;
        joy2 = 12'h000;
        joy_load = 1'b0;
        tick(3);
        joy1 = 12'hFFF;
        tick(5);
        joy_load = 1'b1;
        tick(6);
        joy1 = 12'h000;
        tick(2);
        push_bits(24'hFFF000, 24);
        shift_bits(24, 8);
        check("snap_frame_cnt", {24'b0, frame_cnt}, 32'd6);

        // Abort after 10 bits, clock rise coinciding with load fall, clock toggles while load low
        d0 = done_cnt;
        do_load(12'h001, 12'h800, 8);
        push_bits(24'h7FFFFE, 10);
        shift_bits(10, 8);
        joy_clk = 1'b0;
        tick(8);
        joy1 = 12'h123;
        joy2 = 12'hF0F;
        joy_clk = 1'b1;
        joy_load = 1'b0;
        tick(4);
        joy_clk = 1'b0;
        tick(4);
        joy_clk = 1'b1;
        tick(4);
        check("abort_busy", {31'b0, busy}, 32'd1);
        check("abort_load_data", {31'b0, joy_data}, 32'd0);
        check("abort_no_done", done_cnt, d0);
        check("abort_frame_cnt", {24'b0, frame_cnt}, 32'd6);
        joy_load = 1'b1;
        tick(8);
        push_bits(24'h0F0EDC, 24);
        shift_bits(24, 8);
        check("restart_frame_cnt", {24'b0, frame_cnt}, 32'd7);
        check("restart_done", done_cnt, d0 + 1);

        // Extra clocks after a completed frame are ignored
        d0 = done_cnt;
        push_bits(24'hFFFFFF, 5);
        shift_bits(5, 8);
        check("extra_frame_cnt", {24'b0, frame_cnt}, 32'd7);
        check("extra_no_done", done_cnt, d0);
        check("extra_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of a frame at bit 7
        do_load(12'hFFF, 12'hFFF, 8);
        push_bits(24'h000000, 7);
        shift_bits(7, 8);
        joy_clk = 1'b0;
        tick(8);
        check("pre_rst_data", {31'b0, joy_data}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_data",       {31'b0, joy_data},   32'd1);
        check("mid_rst_busy",       {31'b0, busy},       32'd0);
        check("mid_rst_frame_cnt",  {24'b0, frame_cnt},  32'd0);
        check("mid_rst_frame_done", {31'b0, frame_done}, 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        joy_clk = 1'b1;
        tick(8);
        check("post_rst_data", {31'b0, joy_data}, 32'd1);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        do_load(12'h001, 12'h800, 8);
        push_bits(24'h7FFFFE, 24);
        shift_bits(24, 8);
        check("post_rst_frame_cnt", {24'b0, frame_cnt}, 32'd1);

        // Minimum-timing frames up to the counter wrap
        for (int f = 0; f < 254; f++) begin
            rj1 = 12'($urandom_range(0, 4095));
            rj2 = 12'($urandom_range(0, 4095));
            do_load(rj1, rj2, 4);
            push_bits({~rj2, ~rj1}, 24);
            shift_bits(24, 4);
        end
        check("wrap_255", {24'b0, frame_cnt}, 32'd255);
        d0 = done_cnt;
        do_load(12'hA5A, 12'h3C3, 4);
        push_bits(24'hC3C5A5, 24);
        shift_bits(24, 4);
        check("wrap_0", {24'b0, frame_cnt}, 32'd0);
        check("wrap_done", done_cnt, d0 + 1);

        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joy_db15_tx.md
Name: joy_db15_tx

Overview:
- Adapter-side emulator of the DB15 serial joystick link: the transmitter partner to joy_db15.
- Latches two players' button words on JOY_LOAD and shifts them out on JOY_DATA, one bit per JOY_CLK rising edge, behaving like a chained 74HC165 parallel-in/serial-out register with pull-ups.
- Used in the loopback test core and the joystick-adapter build, where MiSTer drives USER_IN from internal joystick state.

Parameters:
- BTN_BITS, 12, buttons per player; bit order per player is R,L,D,U,A,B,C,D2,E,F,Select,Start (bit0..bit11).
- PLAYERS, 2, number of player words in one frame.
- SYNC_STAGES, 2, metastability flops on each asynchronous pin input.

Ports:
- clk  in  1  system clock, 40-50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- joy1  in  BTN_BITS  player 1 buttons, active-high, synchronous to clk.
- joy2  in  BTN_BITS  player 2 buttons, active-high, synchronous to clk.
- joy_clk  in  1  shift clock from receiver; asynchronous.
- joy_load  in  1  latch strobe from receiver, active-low; asynchronous.
- joy_data  out  1  serial data, active-low (pressed=0).
- frame_done  out  1  one-cycle pulse when the last frame bit has been consumed.
- frame_cnt  out  8  completed-frame counter, wraps 255->0.
- busy  out  1  high in LOAD and SHIFT states.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, joy_data=1, frame_done=0, frame_cnt=0, busy=0, shift register all-ones, bit counter=0. Synchronizer flops reset to 1, so no false edge is seen on release.
- Inputs: joy_clk and joy_load pass through SYNC_STAGES flops, then one edge-detect flop. Receiver guarantees each level of joy_clk/joy_load lasts at least SYNC_STAGES+2 clk cycles; faster input is out of spec.
- Frame:
  - FRAME = PLAYERS*BTN_BITS bits (24 by default).
  - Order: joy1[0] first ... joy1[11], then joy2[0] ... joy2[11].
  - Shift register holds the inverted concatenation {~joy2,~joy1}; the LSB drives joy_data.
- States:
  - IDLE: joy_data=1.
    - joy_load synced low -> LOAD.
  - LOAD: shift register reloads from joy1/joy2 every clk cycle; joy_data = ~joy1[0] of the current cycle; bit counter=0; busy=1.
    - joy_load synced rising edge -> SHIFT. Snapshot frozen at the last LOAD cycle.
  - SHIFT: on each synced joy_clk rising edge, shift right, fill with 1, bit counter +1; joy_data updates in the cycle after the detected edge.
    - When the counter reaches FRAME-1 and another rising edge arrives: pulse frame_done, increment frame_cnt, go to DONE.
  - DONE: joy_data=1 (serial-in tied high); busy=0.
    - Further joy_clk edges are ignored.
    - joy_load low -> LOAD.
- Latency: pin edge to joy_data change is at most SYNC_STAGES+2 clk cycles.
- Boundary conditions:
  - joy_load falling in SHIFT or DONE: abort the current frame, no frame_done, enter LOAD.
  - joy_clk edges while joy_load is low: ignored.
  - joy_clk rising edge and joy_load falling edge detected in the same cycle: load wins, no shift.
  - joy_clk edge in IDLE: ignored.
  - frame_cnt 255 + completed frame -> 0; no sticky flag.
  - reset_n asserted mid-frame: immediate return to reset values.

Decomposition:
- Package joy_db15_pkg:
  - constants BTN_BITS_DEF=12, PLAYERS_DEF=2;
  - state enum {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE};
  - bit-index localparams BTN_R..BTN_START.
- Sub-module sync_edge: SYNC_STAGES-flop synchronizer with reset value 1, outputs level, rise, fall. Instantiated twice, for joy_clk and joy_load.

Test Plan:
- Reset release with joy_clk=joy_load=1 -> joy_data=1, busy=0, frame_cnt=0, no frame_done over 100 cycles.
- joy1=12'h001, joy2=12'h800; load pulse (8 cycles low), then 24 joy_clk pulses (8 cycles high/low) -> receiver samples before each rising edge read bits 0..23 = 0,1x22,0 (active-low); frame_done exactly once; frame_cnt=1; joy_data=1 afterwards.
- joy1 changes 12'h000->12'hFFF while load is low, then 12'h000 after load rises -> shifted player-1 bits all 0 (pressed), i.e. the last LOAD-cycle value.
- Reload after 10 of 24 clocks -> no frame_done, frame_cnt unchanged, the next frame restarts at joy1[0].
- Extra 5 joy_clk pulses after a completed frame -> joy_data stays 1, frame_cnt unchanged; 256 full frames -> frame_cnt=0.
- Assert reset_n mid-SHIFT at bit 7 -> outputs return to reset values within the same cycle (async); the next load/shift frame completes normally.
